// File: rtl/ftdi_pkg.sv
// Shared types and default timing for the FT2232H asynchronous 245-FIFO bridge.
package ftdi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        WR_SETUP,
        WR_LOW,
        RECOVER
    } ftdi_state_t;

    // Default strobe timing in clock cycles at 66 MHz.
    localparam int RD_PULSE_CYC_DEF = 3;
    localparam int WR_PULSE_CYC_DEF = 3;
    localparam int SETUP_CYC_DEF    = 1;
    localparam int RECOVER_CYC_DEF  = 4;
    localparam int CNT_W_DEF        = 3;

endpackage

// File: rtl/ftdi_if.sv
// Fabric-side byte streams of the FTDI bridge: one received stream, one transmit stream.
interface ftdi_if;

    logic [7:0] out_rx_data;
    logic       out_rx_valid;
    logic       in_rx_ready;
    logic [7:0] in_tx_data;
    logic       in_tx_valid;
    logic       out_tx_ready;

    // The bridge drives the rx stream and the tx ready flag.
    modport master (
        output out_rx_data,
        output out_rx_valid,
        input  in_rx_ready,
        input  in_tx_data,
        input  in_tx_valid,
        output out_tx_ready
    );

    modport slave (
        input  out_rx_data,
        input  out_rx_valid,
        output in_rx_ready,
        output in_tx_data,
        output in_tx_valid,
        input  out_tx_ready
    );

endinterface

// File: rtl/ftdi_sync2.sv
// Two-flop synchroniser for the asynchronous FTDI status flags; resets to the inactive (high) level.
module ftdi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ftdi_fifo_if.sv
// FT2232H asynchronous 245-FIFO bridge: generates RD#/WR# strobes and bus direction,
// and exposes one rx and one tx byte stream with 1-byte holding registers.
module ftdi_fifo_if
    import ftdi_pkg::*;
#(
    parameter int RD_PULSE_CYC = RD_PULSE_CYC_DEF,
    parameter int WR_PULSE_CYC = WR_PULSE_CYC_DEF,
    parameter int SETUP_CYC    = SETUP_CYC_DEF,
    parameter int RECOVER_CYC  = RECOVER_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       in_ext_osc,
    input  logic       in_reset_n,
    input  logic       in_ftdi_rxf_n,
    input  logic       in_ftdi_txe_n,
    input  logic [7:0] in_ftdi_data_i,
    output logic [7:0] out_ftdi_data_o,
    output logic       out_ftdi_data_oe,
    output logic       out_ftdi_rd_n,
    output logic       out_ftdi_wr_n,
    ftdi_if.master     fab
);

    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVER_CYC - 1);

    logic rxf_s;
    logic txe_s;

    ftdi_sync2 u_sync_rxf (
        .clk   (in_ext_osc),
        .rst_n (in_reset_n),
        .d     (in_ftdi_rxf_n),
        .q     (rxf_s)
    );

    ftdi_sync2 u_sync_txe (
        .clk   (in_ext_osc),
        .rst_n (in_reset_n),
        .d     (in_ftdi_txe_n),
        .q     (txe_s)
    );

    ftdi_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             prio_wr, prio_wr_nxt;
    logic             rd_n, rd_n_nxt;
    logic             wr_n, wr_n_nxt;
    logic             oe, oe_nxt;
    logic [7:0]       data_o, data_o_nxt;
    logic             rx_valid, rx_valid_nxt;
    logic [7:0]       rx_data, rx_data_nxt;
    logic             tx_ready, tx_ready_nxt;
    logic [7:0]       tx_byte, tx_byte_nxt;

    logic rd_req;
    logic wr_req;
    logic grant_wr;

    always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            prio_wr  <= 1'b0;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            oe       <= 1'b0;
            data_o   <= 8'h00;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            tx_ready <= 1'b1;
            tx_byte  <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prio_wr  <= prio_wr_nxt;
            rd_n     <= rd_n_nxt;
            wr_n     <= wr_n_nxt;
            oe       <= oe_nxt;
            data_o   <= data_o_nxt;
            rx_valid <= rx_valid_nxt;
            rx_data  <= rx_data_nxt;
            tx_ready <= tx_ready_nxt;
            tx_byte  <= tx_byte_nxt;
        end
    end

    // Requests are only acted on in IDLE; prio_wr breaks ties and flips after every transfer.
    always_comb begin
        rd_req   = !rxf_s && !rx_valid;
        wr_req   = !txe_s && !tx_ready;
        grant_wr = wr_req && (!rd_req || prio_wr);

        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        prio_wr_nxt  = prio_wr;
        rd_n_nxt     = rd_n;
        wr_n_nxt     = wr_n;
        oe_nxt       = oe;
        data_o_nxt   = data_o;
        rx_valid_nxt = rx_valid && !fab.in_rx_ready;
        rx_data_nxt  = rx_data;
        tx_ready_nxt = tx_ready;
        tx_byte_nxt  = tx_byte;

        if (tx_ready && fab.in_tx_valid) begin
            tx_ready_nxt = 1'b0;
            tx_byte_nxt  = fab.in_tx_data;
        end

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (grant_wr) begin
                    state_nxt  = WR_SETUP;
                    oe_nxt     = 1'b1;
                    data_o_nxt = tx_byte;
                end else if (rd_req) begin
                    state_nxt = RD_LOW;
                    rd_n_nxt  = 1'b0;
                end
            end
            RD_LOW: begin
                if (cnt == RD_LAST) begin
                    state_nxt    = RECOVER;
                    cnt_nxt      = '0;
                    rd_n_nxt     = 1'b1;
                    rx_data_nxt  = in_ftdi_data_i;
                    rx_valid_nxt = 1'b1;
                    prio_wr_nxt  = !prio_wr;
                end
            end
            WR_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = WR_LOW;
                    cnt_nxt   = '0;
                    wr_n_nxt  = 1'b0;
                end
            end
            WR_LOW: begin
                if (cnt == WR_LAST) begin
                    state_nxt    = RECOVER;
                    cnt_nxt      = '0;
                    wr_n_nxt     = 1'b1;
                    tx_ready_nxt = 1'b1;
                    prio_wr_nxt  = !prio_wr;
                end
            end
            RECOVER: begin
                // Keep the bus driven for one cycle past WR# rising as data hold time.
                if (cnt == '0) begin
                    oe_nxt = 1'b0;
                end
                if (cnt == REC_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign out_ftdi_rd_n    = rd_n;
    assign out_ftdi_wr_n    = wr_n;
    assign out_ftdi_data_oe = oe;
    assign out_ftdi_data_o  = data_o;
    assign fab.out_rx_valid = rx_valid;
    assign fab.out_rx_data  = rx_data;
    assign fab.out_tx_ready = tx_ready;

endmodule

// File: doc/ftdi_fifo_if.md
Name: ftdi_fifo_if

Overview:
FT2232H asynchronous 245-FIFO bridge. It is the stage directly behind the top-level FTDI pins and drives the RD#/WR# strobes and the data-bus direction. On the fabric side it presents one received-byte stream and one transmit-byte stream, each with a valid/ready handshake. The top level owns the io_ftdi_data tristate, built from out_ftdi_data_o and out_ftdi_data_oe; this block never uses inout.

Parameters:
RD_PULSE_CYC, 3, clock cycles RD# is held low (45 ns at 66 MHz); must be >= 2.
WR_PULSE_CYC, 3, clock cycles WR# is held low; must be >= 2.
SETUP_CYC, 1, cycles data is driven with WR# high before WR# falls.
RECOVER_CYC, 4, idle cycles after each strobe rises; must be >= 3 so that a synchronised RXF#/TXE# update is seen before the next decision.
CNT_W, 3, width of the internal cycle counter; must satisfy 2^CNT_W > every *_CYC value.

Ports:
in_ext_osc  input  1  clock, 66 MHz.
in_reset_n  input  1  asynchronous, active-low reset.
in_ftdi_rxf_n  input  1  FTDI RX FIFO has data (active low), asynchronous to the clock.
in_ftdi_txe_n  input  1  FTDI TX FIFO has space (active low), asynchronous to the clock.
in_ftdi_data_i  input  8  pad input data.
out_ftdi_data_o  output  8  pad output data.
out_ftdi_data_oe  output  1  pad output enable.
out_ftdi_rd_n  output  1  read strobe.
out_ftdi_wr_n  output  1  write strobe.
out_rx_data  output  8  received byte.
out_rx_valid  output  1  received byte valid.
in_rx_ready  input  1  fabric accepts the received byte.
in_tx_data  input  8  byte to send.
in_tx_valid  input  1  tx byte valid.
out_tx_ready  output  1  tx holding register empty.

Behaviour:
- Registered outputs only. Reset values: rd_n=1, wr_n=1, data_oe=0, data_o=0x00, rx_valid=0, rx_data=0x00, tx_ready=1. Internal state: state=IDLE, counter=0, priority=read.
- Asserting reset mid-operation forces the reset values immediately (asynchronously). Any half-done transfer is abandoned. The tx holding register is emptied and the byte is lost.
- in_ftdi_rxf_n and in_ftdi_txe_n pass through a 2-FF synchroniser before use. The synchronised versions are rxf_s and txe_s.
- rx holding register (1 byte): out_rx_valid stays high until a cycle in which in_rx_ready=1, and is cleared at that edge. out_rx_data is stable while out_rx_valid=1.
- tx holding register (1 byte): out_tx_ready = !tx_full. When in_tx_valid & out_tx_ready, the byte is captured and tx_full=1.
- Request conditions: rd_req = !rxf_s & !rx_valid; wr_req = !txe_s & tx_full. Decisions are made in IDLE only.
- When both requests are active, they alternate: the priority bit toggles after every completed transfer. When only one request is active, it is served regardless of priority.
- State IDLE: on rd_req granted, go to RD_LOW and set rd_n=0 at the same edge. On wr_req granted, go to WR_SETUP and set oe=1, data_o=tx byte.
- State RD_LOW: rd_n is low for exactly RD_PULSE_CYC cycles. At the edge that ends the pulse: rd_n=1, in_ftdi_data_i is sampled into rx_data, and rx_valid=1. Then go to RECOVER.
- State WR_SETUP: lasts SETUP_CYC cycles, then WR_LOW with wr_n=0.
- State WR_LOW: wr_n is low for exactly WR_PULSE_CYC cycles. data_o and oe hold throughout. At the edge ending the pulse: wr_n=1 and tx_full=0. Then go to RECOVER.
- State RECOVER: lasts RECOVER_CYC cycles, then IDLE. oe drops at the end of the first RECOVER cycle after a write, giving one cycle of data hold past WR# rising.
- Invariants: oe=1 and rd_n=0 never occur together; rd_n and wr_n are never both low; oe is 0 during every RD_LOW.
- Default read-to-read period is 1+3+4 = 8 cycles. Default write period is 1+1+3+4 = 9 cycles.
- A tx byte may be accepted while a read is in progress. An rx byte may be consumed during any state.

Decomposition:
- Package ftdi_pkg holds the state enumeration (IDLE, RD_LOW, WR_SETUP, WR_LOW, RECOVER) and the default timing constants.
- Sub-module ftdi_sync2: a 2-FF synchroniser with asynchronous reset to 1, instantiated once for RXF# and once for TXE#.

Test Plan:
- Reset: release reset with RXF#=TXE#=1 and no tx. Expect all outputs at their reset values, tx_ready=1, and no strobe activity for 20 cycles.
- Single read: RXF#=0, bus driven to 0xA5 while RD# is low, rx_ready=1. Expect RD# low for exactly 3 cycles, then rx_valid=1 with rx_data=0xA5. The next RD# must fall no earlier than 8 cycles after the first.
- Backpressure: RXF#=0, bus increments from 0x00 on each RD# rising edge, rx_ready=0. Expect one read only, with rx_data=0x00 held. Raise rx_ready: 0x00 is consumed, and the next pulse yields 0x01.
- Single write: TXE#=0, push 0x3C. Expect oe=1 with data 0x3C one cycle before WR# falls, WR# low for 3 cycles, and data stable until oe drops one cycle after WR# rises. tx_ready returns to 1 on the WR# rising edge.
- Contention: RXF#=TXE#=0, tx stream 0x10,0x11,0x12, rx_ready=1. Expect the order READ, WRITE, READ, WRITE, READ, WRITE. The assertion checker must never see oe=1 with RD#=0.
- TXE# high and reset mid-write: a pushed byte waits with tx_ready=0 and no WR# pulse. Drop TXE#, then assert reset during WR_LOW. Expect WR#=1, oe=0 and tx_ready=1 immediately.
